button_press_classifier: RTL

BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

---
 rtl/button_press_classifier.sv | 117 +++++++++++
 1 files changed

// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into press/release edges, short and long
// presses with auto-repeat, and a wrapping count of completed presses.
module button_press_classifier #(
    parameter logic [31:0] LONG_TICKS   = 32'd100_000_000,
    parameter logic [31:0] REPEAT_TICKS = 32'd20_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       debounced,
    output logic       rise_tick,
    output logic       fall_tick,
    output logic       short_press,
    output logic       long_press,
    output logic       repeat_tick,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESSED   = 2'b01,
        LONG_HELD = 2'b10
    } state_t;

    state_t      state_r;
    logic [31:0] cnt_r;
    logic        prev_r;
    logic        rise_s;
    logic        fall_s;

    // Edge detection against the level seen at the previous clock edge.
    assign rise_s = debounced & ~prev_r;
    assign fall_s = ~debounced & prev_r;

    // Press classification FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= 32'd0;
            prev_r      <= 1'b0;
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            repeat_tick <= 1'b0;
            held        <= 1'b0;
            press_count <= 8'd0;
        end else begin
            prev_r      <= debounced;
            rise_tick   <= rise_s;
            fall_tick   <= fall_s;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            repeat_tick <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_r <= PRESSED;
                        cnt_r   <= 32'd0;
                        held    <= 1'b1;
                    end else begin
                        held    <= 1'b0;
                    end
                end
                PRESSED: begin
                    // A release on the threshold edge wins over the long-press pulse.
                    if (fall_s) begin
                        state_r     <= IDLE;
                        cnt_r       <= 32'd0;
                        short_press <= 1'b1;
                        press_count <= press_count + 8'd1;
                        held        <= 1'b0;
                    end else if (debounced) begin
                        held <= 1'b1;
                        if (cnt_r == LONG_TICKS - 32'd1) begin
                            state_r    <= LONG_HELD;
                            cnt_r      <= 32'd0;
                            long_press <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 32'd1;
                        end
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= 32'd0;
                        held    <= 1'b0;
                    end
                end
                LONG_HELD: begin
                    if (fall_s) begin
                        state_r     <= IDLE;
                        cnt_r       <= 32'd0;
                        press_count <= press_count + 8'd1;
                        held        <= 1'b0;
                    end else if (debounced) begin
                        held <= 1'b1;
                        if (cnt_r == REPEAT_TICKS - 32'd1) begin
                            cnt_r       <= 32'd0;
                            repeat_tick <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 32'd1;
                        end
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= 32'd0;
                        held    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 32'd0;
                    held    <= 1'b0;
                end
            endcase
        end
    end

endmodule
